pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter unit for the 16-bit RISC core and its wider variants. It holds the current fetch address and advances it each cycle by sequential increment, PC-relative branch, absolute jump, call, or return. Calls and returns use an internal return-address stack (RAS) with overflow and underflow reporting. It sits between the branch/decode logic, which drives the operation code, and instruction memory, which consumes `pc`.

## Interface

Parameters:
- `WIDTH`, 16: address width in bits.
- `RESET_ADDR`, 0: value loaded into `pc` on reset. Must fit in `WIDTH` bits.
- `INC`, 1: sequential increment, in address units.
- `RAS_DEPTH`, 4: number of return-address entries. Must be ≥ 2 and a power of two.

Ports:
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `stall` input 1: when high, holds all state; `op` is ignored.
- `op` input 3: operation for this cycle.
  - 0 SEQ
  - 1 BRANCH (relative)
  - 2 JUMP (absolute)
  - 3 CALL
  - 4 RET
  - 5–7 reserved, treated as SEQ
- `offset` input WIDTH: signed two's-complement displacement, used by BRANCH.
- `target` input WIDTH: absolute address, used by JUMP and CALL.
- `clr_err` input 1: synchronous clear of the sticky error flags.
- `pc` output WIDTH: current fetch address (registered).
- `pc_next` output WIDTH: combinational value `pc` will take at the next edge.
- `ras_empty` output 1: RAS holds 0 entries (registered).
- `ras_full` output 1: RAS holds `RAS_DEPTH` entries (registered).
- `ras_ovf` output 1: sticky flag; a CALL was executed while the RAS was full.
- `ras_unf` output 1: sticky flag; a RET was executed while the RAS was empty.

## Operation

- Reset (async, while `rst`=1): `pc`=`RESET_ADDR`, RAS count=0, top pointer=0, `ras_empty`=1, `ras_full`=0, `ras_ovf`=0, `ras_unf`=0. RAS entry contents are don't-care.
- All arithmetic is modulo 2^WIDTH. Wrap-around is silent: `pc`=2^WIDTH−1 with SEQ and `INC`=1 gives 0.
- `pc_next` for each operation:
  - SEQ: `pc`+`INC`.
  - BRANCH: `pc`+`offset`, with `offset` sign-extended to WIDTH (for example `offset`=0xFFFE means −2).
  - JUMP: `target`.
  - CALL: `target`. Also pushes `pc`+`INC` onto the RAS.
  - RET, RAS non-empty: the top entry. Also pops it.
  - RET, RAS empty: `pc`+`INC`. Sets `ras_unf`; RAS is unchanged.
- `stall`=1: `pc_next`=`pc`. No push, no pop, no flag set. `clr_err` is still honoured.
- RAS is a circular buffer with a top pointer and a count from 0 to `RAS_DEPTH`.
- Push while full: the oldest entry is overwritten, so the stack keeps the newest `RAS_DEPTH` return addresses. Count stays at `RAS_DEPTH` and `ras_ovf` is set.
- No simultaneous push and pop can occur, since `op` is a single code.
- `clr_err` and a new error event in the same cycle: the flag ends up set (set wins).
- `ras_empty` and `ras_full` reflect the count after the edge.

## Timing

- Latency: the `pc` update is visible 1 cycle after the edge at which `op` is sampled. `pc_next` is valid in the same cycle, combinationally from `pc`, `op`, `stall`, `offset`, `target` and the RAS top.
- Throughput: one operation per cycle, including back-to-back CALL/RET. A RET immediately after a CALL returns the address pushed on the previous cycle.
- The RAS top read path is combinational from registered state; there is no bypass from the same-cycle push.
- Reset asserted mid-sequence: outputs take their reset values immediately, independent of `clk`. Operation resumes from `RESET_ADDR` on the first edge after `rst` is released.

## Test plan

- Reset and SEQ: assert `rst` with `pc`=0x1234 → `pc`=0x0000 without a clock edge. Release reset, drive SEQ for 3 cycles → `pc` goes 1, 2, 3. Set `pc`=0xFFFF, drive SEQ → `pc`=0x0000.
- BRANCH and JUMP: `pc`=0x0010 with `offset`=0xFFFE → `pc`=0x000E. Then JUMP with `target`=0x0400 → `pc`=0x0400.
- Stall: `stall`=1 with `op`=CALL and `target`=0x0200 for 2 cycles → `pc` and RAS count unchanged, and `pc_next`=`pc`.
- Nested calls, default depth 4: CALL at 0x10, 0x20, 0x30 and 0x40, each to `target`=previous+0x10 → `ras_full`=1. Four RETs → `pc` goes 0x41, 0x31, 0x21, 0x11, then `ras_empty`=1, with no flags set.
- Overflow: 5 CALLs from `pc`=0x10, 0x20, 0x30, 0x40, 0x50 → `ras_ovf`=1. Four RETs yield 0x51, 0x41, 0x31, 0x21. A fifth RET gives `pc`=`pc`+1 and `ras_unf`=1.
- Flag clear: with both flags set, pulse `clr_err` → both flags are 0. Pulse `clr_err` again together with a RET on an empty stack → `ras_unf`=1.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch-control bus between branch/decode logic (master) and the PC sequencer (slave).
interface pc_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             stall;
  logic [2:0]       op;
  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] target;
  logic             clr_err;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_next;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_ovf;
  logic             ras_unf;

  modport master (
    output stall, op, offset, target, clr_err,
    input  pc, pc_next, ras_empty, ras_full, ras_ovf, ras_unf
  );

  modport slave (
    input  stall, op, offset, target, clr_err,
    output pc, pc_next, ras_empty, ras_full, ras_ovf, ras_unf
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter with sequential/branch/jump/call/return and a circular return-address stack.
module pc_sequencer #(
  parameter int          WIDTH      = 16,
  parameter int unsigned RESET_ADDR = 0,
  parameter int unsigned INC        = 1,
  parameter int          RAS_DEPTH  = 4
) (
  input logic            clk,
  input logic            rst,
  pc_sequencer_if.slave  bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [WIDTH-1:0] RST_PC   = WIDTH'(RESET_ADDR);
  localparam logic [WIDTH-1:0] INC_W    = WIDTH'(INC);
  localparam logic [CW-1:0]    FULL_CNT = CW'(RAS_DEPTH);

  localparam logic [2:0] OP_BRANCH = 3'd1;
  localparam logic [2:0] OP_JUMP   = 3'd2;
  localparam logic [2:0] OP_CALL   = 3'd3;
  localparam logic [2:0] OP_RET    = 3'd4;

  logic [WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]    top_q, top_d, top_inc;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             empty_q, full_q, ovf_q, unf_q;
  logic             do_push, do_pop, set_ovf, set_unf;

  assign pc_inc  = pc_q + INC_W;
  assign top_inc = top_q + 1'b1;

  always_comb begin
    pc_d    = pc_q;
    do_push = 1'b0;
    do_pop  = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (!bus.stall) begin
      case (bus.op)
        OP_BRANCH: pc_d = pc_q + bus.offset;
        OP_JUMP:   pc_d = bus.target;
        OP_CALL: begin
          pc_d    = bus.target;
          do_push = 1'b1;
          set_ovf = (cnt_q == FULL_CNT);
        end
        OP_RET: begin
          if (cnt_q != '0) begin
            pc_d   = ras[top_q];
            do_pop = 1'b1;
          end else begin
            pc_d    = pc_inc;
            set_unf = 1'b1;
          end
        end
        default:   pc_d = pc_inc;
      endcase
    end
  end

  // A push while full keeps the count saturated; the slot written is the oldest one.
  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    if (do_push) begin
      top_d = top_inc;
      cnt_d = (cnt_q == FULL_CNT) ? cnt_q : cnt_q + 1'b1;
    end else if (do_pop) begin
      top_d = top_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RST_PC;
      top_q   <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == FULL_CNT);
      ovf_q   <= set_ovf | (ovf_q & ~bus.clr_err);
      unf_q   <= set_unf | (unf_q & ~bus.clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) ras[top_inc] <= pc_inc;
  end

  assign bus.pc        = pc_q;
  assign bus.pc_next   = pc_d;
  assign bus.ras_empty = empty_q;
  assign bus.ras_full  = full_q;
  assign bus.ras_ovf   = ovf_q;
  assign bus.ras_unf   = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: queue-based reference model checked every cycle, plus literal checkpoints.
module tb_pc_sequencer;
  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  bit   checking = 0;

  pc_sequencer_if #(.WIDTH(16)) bus ();

  pc_sequencer #(.WIDTH(16), .RESET_ADDR(0), .INC(1), .RAS_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: return stack as a queue holding at most 4 newest addresses.
  logic [15:0] m_pc;
  logic [15:0] m_ras[$];
  bit          m_ovf, m_unf;
  logic [15:0] m_nxt;
  bit          s_ovf, s_unf;

  function automatic logic [15:0] model_next();
    if (bus.stall) return m_pc;
    case (bus.op)
      3'd1:       return m_pc + bus.offset;
      3'd2, 3'd3: return bus.target;
      3'd4:       return (m_ras.size() > 0) ? m_ras[$] : m_pc + 16'd1;
      default:    return m_pc + 16'd1;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 16'h0000;
      m_ras.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      m_nxt = model_next();
      s_ovf = 0;
      s_unf = 0;
      if (!bus.stall) begin
        if (bus.op == 3'd3) begin
          m_ras.push_back(m_pc + 16'd1);
          if (m_ras.size() > 4) begin
            void'(m_ras.pop_front());
            s_ovf = 1;
          end
        end else if (bus.op == 3'd4) begin
          if (m_ras.size() > 0) void'(m_ras.pop_back());
          else s_unf = 1;
        end
      end
      m_ovf = s_ovf | (m_ovf & !bus.clr_err);
      m_unf = s_unf | (m_unf & !bus.clr_err);
      m_pc  = m_nxt;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("m_pc",      32'(bus.pc),        32'(m_pc));
      chk("m_pc_next", 32'(bus.pc_next),   32'(model_next()));
      chk("m_empty",   32'(bus.ras_empty), 32'(m_ras.size() == 0));
      chk("m_full",    32'(bus.ras_full),  32'(m_ras.size() == 4));
      chk("m_ovf",     32'(bus.ras_ovf),   32'(m_ovf));
      chk("m_unf",     32'(bus.ras_unf),   32'(m_unf));
    end
  end

  task automatic step(input logic [2:0] o, input logic [15:0] off = 16'h0,
                      input logic [15:0] tgt = 16'h0, input logic st = 1'b0,
                      input logic cl = 1'b0);
    bus.op      = o;
    bus.offset  = off;
    bus.target  = tgt;
    bus.stall   = st;
    bus.clr_err = cl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    bus.op      = 3'd0;
    bus.offset  = 16'h0;
    bus.target  = 16'h0;
    bus.stall   = 1'b0;
    bus.clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", 32'(bus.pc), 32'h0);
    chk("rst_empty", 32'(bus.ras_empty), 32'h1);
    rst = 1'b0;
    checking = 1;

    // Async reset mid-cycle
    step(3'd2, 16'h0, 16'h1234);
    chk("jump_1234", 32'(bus.pc), 32'h1234);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pc", 32'(bus.pc), 32'h0);
    chk("async_rst_flags", {28'h0, bus.ras_empty, bus.ras_full, bus.ras_ovf, bus.ras_unf}, 32'h8);
    @(posedge clk);
    #1 rst = 1'b0;

    step(3'd0); chk("seq1", 32'(bus.pc), 32'h1);
    step(3'd0); chk("seq2", 32'(bus.pc), 32'h2);
    step(3'd0); chk("seq3", 32'(bus.pc), 32'h3);
    step(3'd2, 16'h0, 16'hFFFF);
    step(3'd0); chk("seq_wrap", 32'(bus.pc), 32'h0);
    step(3'd6); chk("reserved_seq", 32'(bus.pc), 32'h1);

    step(3'd2, 16'h0, 16'h0010);
    step(3'd1, 16'hFFFE); chk("branch_back", 32'(bus.pc), 32'h000E);
    step(3'd1, 16'h0005); chk("branch_fwd", 32'(bus.pc), 32'h0013);
    step(3'd2, 16'h0, 16'h0400); chk("jump_400", 32'(bus.pc), 32'h0400);

    // Stall holds everything even with a CALL presented
    bus.stall = 1'b1; bus.op = 3'd3; bus.target = 16'h0200;
    #1 chk("stall_pc_next", 32'(bus.pc_next), 32'h0400);
    step(3'd3, 16'h0, 16'h0200, 1'b1);
    step(3'd3, 16'h0, 16'h0200, 1'b1);
    chk("stall_pc", 32'(bus.pc), 32'h0400);
    chk("stall_empty", 32'(bus.ras_empty), 32'h1);

    // Nested calls to full depth
    step(3'd2, 16'h0, 16'h0010);
    step(3'd3, 16'h0, 16'h0020);
    step(3'd3, 16'h0, 16'h0030);
    step(3'd3, 16'h0, 16'h0040);
    step(3'd3, 16'h0, 16'h0050);
    chk("nest_full", 32'(bus.ras_full), 32'h1);
    step(3'd4); chk("nest_ret1", 32'(bus.pc), 32'h41);
    step(3'd4); chk("nest_ret2", 32'(bus.pc), 32'h31);
    step(3'd4); chk("nest_ret3", 32'(bus.pc), 32'h21);
    step(3'd4); chk("nest_ret4", 32'(bus.pc), 32'h11);
    chk("nest_flags", {28'h0, bus.ras_empty, bus.ras_full, bus.ras_ovf, bus.ras_unf}, 32'h8);

    // Overflow then underflow
    step(3'd2, 16'h0, 16'h0010);
    step(3'd3, 16'h0, 16'h0020);
    step(3'd3, 16'h0, 16'h0030);
    step(3'd3, 16'h0, 16'h0040);
    step(3'd3, 16'h0, 16'h0050);
    step(3'd3, 16'h0, 16'h0060);
    chk("ovf_set", 32'(bus.ras_ovf), 32'h1);
    step(3'd4); chk("ovf_ret1", 32'(bus.pc), 32'h51);
    step(3'd4); chk("ovf_ret2", 32'(bus.pc), 32'h41);
    step(3'd4); chk("ovf_ret3", 32'(bus.pc), 32'h31);
    step(3'd4); chk("ovf_ret4", 32'(bus.pc), 32'h21);
    step(3'd4); chk("unf_pc", 32'(bus.pc), 32'h22);
    chk("unf_set", 32'(bus.ras_unf), 32'h1);

    // Flag clear, and set-wins on coincident clear
    step(3'd0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("clr_flags", {30'h0, bus.ras_ovf, bus.ras_unf}, 32'h0);
    step(3'd4, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("clr_set_wins", 32'(bus.ras_unf), 32'h1);
    step(3'd0, 16'h0, 16'h0, 1'b1, 1'b1);
    chk("clr_in_stall", 32'(bus.ras_unf), 32'h0);

    // Back-to-back CALL/RET
    step(3'd3, 16'h0, 16'h0300);
    step(3'd4); chk("call_ret", 32'(bus.pc), 32'h0025);
    step(3'd0);

    checking = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
